// File: rtl/bf_core_ctrl.sv
// Brainfuck execution controller: fetches opcodes from an instruction port and
// drives a data-cell port plus byte input/output streams, with a bounded loop stack.
module bf_core_ctrl #(
   parameter int PC_W  = 8,
   parameter int DP_W  = 8,
   parameter int STK_D = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [7:0]      imem_rdata,
   input  logic            imem_ack,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [DP_W-1:0] dmem_addr,
   output logic [7:0]      dmem_wdata,
   input  logic [7:0]      dmem_rdata,
   input  logic            dmem_ack,
   input  logic            in_valid,
   input  logic [7:0]      in_data,
   output logic            in_ready,
   output logic            out_valid,
   output logic [7:0]      out_data,
   input  logic            out_ready
);

   localparam int SP_W  = $clog2(STK_D + 1);
   localparam int IDX_W = (STK_D > 1) ? $clog2(STK_D) : 1;

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_FETCH = 4'd1;
   localparam logic [3:0] S_EXEC  = 4'd2;
   localparam logic [3:0] S_RD    = 4'd3;
   localparam logic [3:0] S_WR    = 4'd4;
   localparam logic [3:0] S_OUT   = 4'd5;
   localparam logic [3:0] S_IN    = 4'd6;
   localparam logic [3:0] S_SKIP  = 4'd7;
   localparam logic [3:0] S_HALT  = 4'd8;
   localparam logic [3:0] S_ERR   = 4'd9;

   localparam logic [7:0] OP_RIGHT = 8'h3E;
   localparam logic [7:0] OP_LEFT  = 8'h3C;
   localparam logic [7:0] OP_INC   = 8'h2B;
   localparam logic [7:0] OP_DEC   = 8'h2D;
   localparam logic [7:0] OP_OUT   = 8'h2E;
   localparam logic [7:0] OP_IN    = 8'h2C;
   localparam logic [7:0] OP_LOOP  = 8'h5B;
   localparam logic [7:0] OP_END   = 8'h5D;
   localparam logic [7:0] OP_HALT  = 8'h00;

   localparam logic [PC_W-1:0] PC_ZERO   = {PC_W{1'b0}};
   localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1'b1);
   localparam logic [PC_W-1:0] PC_MAX    = {PC_W{1'b1}};
   localparam logic [DP_W-1:0] DP_ZERO   = {DP_W{1'b0}};
   localparam logic [DP_W-1:0] DP_ONE    = DP_W'(1'b1);
   localparam logic [SP_W-1:0] SP_ZERO   = {SP_W{1'b0}};
   localparam logic [SP_W-1:0] SP_ONE    = SP_W'(1'b1);
   localparam logic [SP_W-1:0] SP_FULL   = SP_W'(STK_D);
   localparam logic [PC_W:0]   DEPTH_ONE = (PC_W+1)'(1'b1);

   logic [3:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [DP_W-1:0] dp_q, dp_d;
   logic [SP_W-1:0] sp_q, sp_d;
   logic [7:0]      ir_q, ir_d;
   logic [7:0]      cell_q, cell_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [PC_W:0]   depth_q, depth_d;
   logic [PC_W-1:0] stk_q [STK_D];

   logic            push_s;
   logic [IDX_W-1:0] push_idx_s, top_idx_s;
   logic [3:0]      adv_state_s;
   logic [PC_W-1:0] adv_pc_s;

   assign push_idx_s  = IDX_W'(sp_q);
   assign top_idx_s   = IDX_W'(sp_q - SP_ONE);
   // Stepping past the last instruction address is a normal halt, not a wrap.
   assign adv_state_s = (pc_q == PC_MAX) ? S_HALT : S_FETCH;
   assign adv_pc_s    = (pc_q == PC_MAX) ? pc_q : pc_q + PC_ONE;

   // Next-state and datapath decode.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      dp_d    = dp_q;
      sp_d    = sp_q;
      ir_d    = ir_q;
      cell_d  = cell_q;
      wdata_d = wdata_q;
      depth_d = depth_q;
      push_s  = 1'b0;
      case (state_q)
         S_IDLE, S_HALT, S_ERR: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = PC_ZERO;
               dp_d    = DP_ZERO;
               sp_d    = SP_ZERO;
            end else begin
               state_d = state_q;
            end
         end
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_EXEC;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            case (ir_q)
               OP_RIGHT: begin dp_d = dp_q + DP_ONE; pc_d = adv_pc_s; state_d = adv_state_s; end
               OP_LEFT:  begin dp_d = dp_q - DP_ONE; pc_d = adv_pc_s; state_d = adv_state_s; end
               OP_INC, OP_DEC, OP_OUT, OP_LOOP: state_d = S_RD;
               OP_END:   state_d = (sp_q == SP_ZERO) ? S_ERR : S_RD;
               OP_IN:    state_d = S_IN;
               OP_HALT:  state_d = S_HALT;
               default:  begin pc_d = adv_pc_s; state_d = adv_state_s; end
            endcase
         end
         S_RD: begin
            if (dmem_ack) begin
               cell_d = dmem_rdata;
               case (ir_q)
                  OP_INC: begin wdata_d = dmem_rdata + 8'd1; state_d = S_WR; end
                  OP_DEC: begin wdata_d = dmem_rdata - 8'd1; state_d = S_WR; end
                  OP_OUT: state_d = S_OUT;
                  OP_LOOP: begin
                     if (dmem_rdata != 8'h00) begin
                        if (sp_q == SP_FULL) begin
                           state_d = S_ERR;
                        end else begin
                           push_s  = 1'b1;
                           sp_d    = sp_q + SP_ONE;
                           pc_d    = adv_pc_s;
                           state_d = adv_state_s;
                        end
                     end else if (pc_q == PC_MAX) begin
                        state_d = S_ERR;
                     end else begin
                        depth_d = DEPTH_ONE;
                        pc_d    = pc_q + PC_ONE;
                        state_d = S_SKIP;
                     end
                  end
                  OP_END: begin
                     if (dmem_rdata != 8'h00) begin
                        pc_d    = stk_q[top_idx_s] + PC_ONE;
                        state_d = S_FETCH;
                     end else begin
                        sp_d    = sp_q - SP_ONE;
                        pc_d    = adv_pc_s;
                        state_d = adv_state_s;
                     end
                  end
                  default: state_d = S_ERR;
               endcase
            end else begin
               state_d = S_RD;
            end
         end
         S_WR: begin
            if (dmem_ack) begin
               pc_d    = adv_pc_s;
               state_d = adv_state_s;
            end else begin
               state_d = S_WR;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               pc_d    = adv_pc_s;
               state_d = adv_state_s;
            end else begin
               state_d = S_OUT;
            end
         end
         S_IN: begin
            if (in_valid) begin
               wdata_d = in_data;
               state_d = S_WR;
            end else begin
               state_d = S_IN;
            end
         end
         S_SKIP: begin
            if (!imem_ack) begin
               state_d = S_SKIP;
            end else if (imem_rdata == OP_HALT) begin
               state_d = S_ERR;
            end else if ((imem_rdata == OP_END) && (depth_q == DEPTH_ONE)) begin
               pc_d    = adv_pc_s;
               state_d = adv_state_s;
            end else begin
               if (imem_rdata == OP_LOOP) begin
                  depth_d = depth_q + DEPTH_ONE;
               end else if (imem_rdata == OP_END) begin
                  depth_d = depth_q - DEPTH_ONE;
               end else begin
                  depth_d = depth_q;
               end
               if (pc_q == PC_MAX) begin
                  state_d = S_ERR;
               end else begin
                  pc_d = pc_q + PC_ONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= PC_ZERO;
         dp_q    <= DP_ZERO;
         sp_q    <= SP_ZERO;
         ir_q    <= 8'h00;
         cell_q  <= 8'h00;
         wdata_q <= 8'h00;
         depth_q <= {(PC_W+1){1'b0}};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         dp_q    <= dp_d;
         sp_q    <= sp_d;
         ir_q    <= ir_d;
         cell_q  <= cell_d;
         wdata_q <= wdata_d;
         depth_q <= depth_d;
      end
   end

   // Loop return stack holds the address of each open '['.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STK_D; i++) stk_q[i] <= PC_ZERO;
      end else if (push_s) begin
         stk_q[push_idx_s] <= pc_q;
      end
   end

   assign busy       = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
   assign done       = (state_q == S_HALT);
   assign err        = (state_q == S_ERR);
   assign imem_req   = (state_q == S_FETCH) || (state_q == S_SKIP);
   assign imem_addr  = pc_q;
   assign dmem_req   = (state_q == S_RD) || (state_q == S_WR);
   assign dmem_we    = (state_q == S_WR);
   assign dmem_addr  = dp_q;
   assign dmem_wdata = wdata_q;
   assign out_valid  = (state_q == S_OUT);
   assign out_data   = cell_q;
   assign in_ready   = (state_q == S_IN);

endmodule

// File: tb/tb_bf_core_ctrl.sv
// Directed bench for bf_core_ctrl: small programs against behavioural
// instruction/data memories with hand-computed expected results.
module tb_bf_core_ctrl;
   localparam int PC_W = 8, DP_W = 8, STK_D = 8;

   logic clk = 1'b0;
   logic rst_n, start;
   logic busy, done, err;
   logic imem_req, imem_ack;
   logic [PC_W-1:0] imem_addr;
   logic [7:0] imem_rdata;
   logic dmem_req, dmem_we, dmem_ack;
   logic [DP_W-1:0] dmem_addr;
   logic [7:0] dmem_wdata, dmem_rdata;
   logic in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_data, out_data;

   logic [7:0] imem [256];
   logic [7:0] dmem [256];
   int imem_lat = 0;
   int iw_cnt = 0;
   logic dmem_clr = 1'b0;
   int wr_cnt = 0, wr0_cnt = 0, out_cnt = 0, busy_cnt = 0;
   logic [7:0] wr_addr_last = 8'h00, wr_data_last = 8'h00, out_last = 8'h00;
   int checks = 0, errors = 0;
   int out_base, wr0_base, busy_base;

   always #5 clk = ~clk;

   bf_core_ctrl #(.PC_W(PC_W), .DP_W(DP_W), .STK_D(STK_D)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready));

   assign imem_ack   = imem_req && (iw_cnt >= imem_lat);
   assign imem_rdata = imem[imem_addr];
   assign dmem_ack   = dmem_req;
   assign dmem_rdata = dmem[dmem_addr];

   always @(posedge clk) begin
      if (imem_req && !imem_ack) iw_cnt <= iw_cnt + 1;
      else iw_cnt <= 0;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (out_valid && out_ready) begin
         out_cnt  <= out_cnt + 1;
         out_last <= out_data;
      end
      if (dmem_clr) begin
         for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
      end else if (dmem_req && dmem_we) begin
         dmem[dmem_addr] <= dmem_wdata;
         wr_cnt       <= wr_cnt + 1;
         wr_addr_last <= dmem_addr;
         wr_data_last <= dmem_wdata;
         if (dmem_addr == 8'h00) wr0_cnt <= wr0_cnt + 1;
      end
   end

   task automatic load(input string p);
      @(negedge clk);
      dmem_clr = 1'b1;
      for (int i = 0; i < 256; i++) imem[i] = 8'h00;
      for (int i = 0; i < p.len(); i++) imem[i] = p[i];
      @(negedge clk);
      dmem_clr = 1'b0;
   endtask

   task automatic pulse_start();
      out_base  = out_cnt;
      wr0_base  = wr0_cnt;
      busy_base = busy_cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input int max_cyc);
      int n = 0;
      while (!(done || err) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= max_cyc) begin
         errors++;
         $display("FAIL run_timeout: no halt/error within %0d cycles", max_cyc);
      end
   endtask

   task automatic run(input string p);
      load(p);
      pulse_start();
      wait_end(2000);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, err, imem_req, dmem_req, out_valid, in_ready} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0000000",
                  {busy, done, err, imem_req, dmem_req, out_valid, in_ready});
      end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++;
      if ({busy, imem_req, dmem_req, dut.state_q} !== 7'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b imem_req=%b dmem_req=%b state=%0d want all 0",
                  busy, imem_req, dmem_req, dut.state_q);
      end
   endtask

   task automatic test_plus_out();
      run("+++.");
      checks++;
      if (out_cnt - out_base !== 1 || out_last !== 8'h03) begin
         errors++;
         $display("FAIL plus_out got n=%0d data=%h want n=1 data=03", out_cnt - out_base, out_last);
      end
      checks++;
      if ({done, err} !== 2'b10 || dmem[0] !== 8'h03) begin
         errors++;
         $display("FAIL plus_out_end got done=%b err=%b cell0=%h want 1 0 03", done, err, dmem[0]);
      end
   endtask

   task automatic test_latency();
      run(">>");
      checks++;
      if (busy_cnt - busy_base !== 6) begin
         errors++;
         $display("FAIL lat_move got %0d want 6", busy_cnt - busy_base);
      end
      run("+");
      checks++;
      if (busy_cnt - busy_base !== 6) begin
         errors++;
         $display("FAIL lat_inc got %0d want 6", busy_cnt - busy_base);
      end
      run("+>.");
      checks++;
      if (busy_cnt - busy_base !== 12) begin
         errors++;
         $display("FAIL lat_mix got %0d want 12", busy_cnt - busy_base);
      end
      run(">>+");
      checks++;
      if (wr_addr_last !== 8'h02 || wr_data_last !== 8'h01) begin
         errors++;
         $display("FAIL dp_inc got addr=%h data=%h want 02 01", wr_addr_last, wr_data_last);
      end
   endtask

   task automatic test_dec_wrap();
      run("<-");
      checks++;
      if (wr_addr_last !== 8'hFF || wr_data_last !== 8'hFF || done !== 1'b1) begin
         errors++;
         $display("FAIL dec_wrap got addr=%h data=%h done=%b want ff ff 1",
                  wr_addr_last, wr_data_last, done);
      end
   endtask

   task automatic test_skip();
      run("[+].");
      checks++;
      if (wr0_cnt - wr0_base !== 0 || out_cnt - out_base !== 1 || out_last !== 8'h00 || done !== 1'b1) begin
         errors++;
         $display("FAIL skip got wr0=%0d n=%0d data=%h done=%b want 0 1 00 1",
                  wr0_cnt - wr0_base, out_cnt - out_base, out_last, done);
      end
   endtask

   task automatic test_loop();
      run("++[->+<]>.");
      checks++;
      if (out_last !== 8'h02 || out_cnt - out_base !== 1) begin
         errors++;
         $display("FAIL loop_out got data=%h n=%0d want 02 1", out_last, out_cnt - out_base);
      end
      checks++;
      if (dut.sp_q !== 4'd0 || done !== 1'b1 || dmem[0] !== 8'h00 || dmem[1] !== 8'h02) begin
         errors++;
         $display("FAIL loop_state got sp=%0d done=%b c0=%h c1=%h want 0 1 00 02",
                  dut.sp_q, done, dmem[0], dmem[1]);
      end
   endtask

   task automatic test_input();
      in_data = 8'hA5; in_valid = 1'b1;
      run(",.");
      in_valid = 1'b0;
      checks++;
      if (out_last !== 8'hA5 || dmem[0] !== 8'hA5 || done !== 1'b1) begin
         errors++;
         $display("FAIL input got out=%h cell0=%h done=%b want a5 a5 1", out_last, dmem[0], done);
      end
   endtask

   task automatic test_errors();
      string s = "";
      run("]");
      checks++;
      if ({done, err} !== 2'b01) begin
         errors++;
         $display("FAIL underflow got done=%b err=%b want 0 1", done, err);
      end
      run("[");
      checks++;
      if ({done, err} !== 2'b01) begin
         errors++;
         $display("FAIL unmatched got done=%b err=%b want 0 1", done, err);
      end
      for (int i = 0; i < 8; i++) s = {s, "+["};
      run(s);
      checks++;
      if ({done, err} !== 2'b10 || dut.sp_q !== 4'd8) begin
         errors++;
         $display("FAIL depth8 got done=%b err=%b sp=%0d want 1 0 8", done, err, dut.sp_q);
      end
      s = {s, "+["};
      run(s);
      checks++;
      if ({done, err} !== 2'b01 || dut.sp_q !== 4'd8 || dmem[0] !== 8'h09) begin
         errors++;
         $display("FAIL overflow got done=%b err=%b sp=%0d c0=%h want 0 1 8 09",
                  done, err, dut.sp_q, dmem[0]);
      end
      load(".");
      pulse_start();
      checks++;
      if ({busy, err, done} !== 3'b100) begin
         errors++;
         $display("FAIL restart got busy=%b err=%b done=%b want 1 0 0", busy, err, done);
      end
      wait_end(100);
   endtask

   task automatic test_stall_reset();
      int n = 0;
      bit stable = 1'b1;
      imem_lat = 3;
      run("+.");
      checks++;
      if (out_last !== 8'h01 || done !== 1'b1) begin
         errors++;
         $display("FAIL slow_imem got data=%h done=%b want 01 1", out_last, done);
      end
      load(".");
      out_ready = 1'b0;
      pulse_start();
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 40) begin
         errors++;
         $display("FAIL out_wait_timeout got no out_valid in 40 cycles");
      end
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (out_valid !== 1'b1 || out_data !== 8'h00) stable = 1'b0;
      end
      checks++;
      if (!stable || dut.pc_q !== 8'h00 || dut.state_q !== 4'd5) begin
         errors++;
         $display("FAIL out_hold got stable=%b pc=%h state=%0d want 1 00 5", stable, dut.pc_q, dut.state_q);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, imem_req, busy, dut.state_q} !== 7'b0) begin
         errors++;
         $display("FAIL mid_reset got out_valid=%b imem_req=%b busy=%b state=%0d want 0 0 0 0",
                  out_valid, imem_req, busy, dut.state_q);
      end
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1; imem_lat = 0;
      repeat (4) @(negedge clk);
      checks++;
      if ({busy, imem_req, dut.state_q} !== 6'b0) begin
         errors++;
         $display("FAIL post_reset_idle got busy=%b imem_req=%b state=%0d want 0 0 0",
                  busy, imem_req, dut.state_q);
      end
   endtask

   initial begin
      test_reset();
      test_plus_out();
      test_latency();
      test_dec_wrap();
      test_skip();
      test_loop();
      test_input();
      test_errors();
      test_stall_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bf_core_ctrl.md
BF_CORE_CTRL -- requirements
Module: bf_core_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 8, instruction address width.
REQ-002 SHALL have parameter DP_W, default 8, data pointer width.
REQ-003 SHALL have parameter STK_D, default 8, loop return-stack depth in entries.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse; begins a program at PC=0; ignored while busy=1.
REQ-007 busy  out  1  high from the cycle after accepted start until halt or error.
REQ-008 done  out  1  level; normal halt; cleared by next accepted start.
REQ-009 err  out  1  level; stack overflow, stack underflow or unmatched '['; cleared by next accepted start.
REQ-010 imem_req  out  1 / imem_addr  out  PC_W / imem_rdata  in  8 / imem_ack  in  1  program fetch port.
REQ-011 dmem_req  out  1 / dmem_we  out  1 / dmem_addr  out  DP_W / dmem_wdata  out  8 / dmem_rdata  in  8 / dmem_ack  in  1  data cell port.
REQ-012 in_valid  in  1 / in_data  in  8 / in_ready  out  1  input byte stream (',').
REQ-013 out_valid  out  1 / out_data  out  8 / out_ready  in  1  output byte stream ('.').

Function
REQ-014 States SHALL be IDLE, FETCH, EXEC, RD, WR, OUT, IN, SKIP, HALT, ERR.
REQ-015 Memory handshakes SHALL hold req and address/data stable until ack is sampled high; ack and req high in the same cycle completes the transaction; ack with req low is ignored.
REQ-016 IDLE + start: PC=0, DP=0, SP=0, done=err=0, go FETCH.
REQ-017 FETCH: imem_addr=PC; on ack latch imem_rdata as IR, go EXEC.
REQ-018 Opcodes: 0x3E '>' DP+1; 0x3C '<' DP-1; 0x2B '+'; 0x2D '-'; 0x2E '.'; 0x2C ','; 0x5B '['; 0x5D ']'; 0x00 halt; any other byte is a NOP (PC+1).
REQ-019 DP arithmetic SHALL be modulo 2^DP_W (wrap both ways); cell arithmetic SHALL be modulo 256.
REQ-020 '>', '<', NOP SHALL complete in EXEC; zero-wait latency 2 cycles per instruction (FETCH + EXEC).
REQ-021 '+'/'-': RD (read cell at DP) then WR (write cell±1), PC+1; zero-wait latency 4 cycles.
REQ-022 '.': RD, then OUT holding out_valid=1, out_data=cell until out_ready; PC+1.
REQ-023 ',': IN holding in_ready=1 until in_valid; WR in_data to cell at DP; PC+1.
REQ-024 '[': RD; cell!=0: push PC, PC+1; cell==0: SKIP with depth=1 and PC+1.
REQ-025 SKIP SHALL fetch sequentially: '[' depth+1, ']' depth-1, other bytes ignored; at depth 0 set PC to the matching ']' address +1, go FETCH.
REQ-026 ']': RD; cell!=0: PC=top+1, stack unchanged; cell==0: pop, PC+1.
REQ-027 Push with SP==STK_D, ']' with SP==0, or SKIP fetching 0x00 or passing max PC SHALL go ERR.
REQ-028 Opcode 0x00, or PC increment from 2^PC_W-1, SHALL go HALT.
REQ-029 HALT/ERR: busy=0, done=1 or err=1 respectively, all req/valid/ready low; next start restarts (REQ-016).
REQ-030 SKIP depth counter SHALL be PC_W+1 bits; it never wraps.
REQ-031 start during busy SHALL have no effect on any state.
REQ-032 Only one of imem_req, dmem_req, out_valid, in_ready SHALL be high in any cycle.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, PC=DP=SP=0, IR=0, all outputs 0 (including any in-flight req, valid, ready), regardless of pending handshake.
REQ-034 After rst_n rises the block SHALL remain IDLE until start.

Verification
REQ-035 Program "+++." with zero-wait memories, cell0=0 -> out_data=0x03 one transfer, then 0x00 -> done=1, cell0=0x03.
REQ-036 Program "<-" -> dmem write addr 2^DP_W-1, data 0xFF (cell initially 0), done=1.
REQ-037 Program "[+]." with cell0=0 -> SKIP, no write to cell0, out_data=0x00, done=1.
REQ-038 Program "++[->+<]>." -> out_data=0x02; stack returns to SP=0; done=1.
REQ-039 Program "]" -> err=1, done=0; program with 9 nested "+[" (STK_D=8) -> err=1 at ninth push.
REQ-040 imem_ack delayed 3 cycles and out_ready held low 5 cycles, then rst_n pulsed low mid-OUT -> out_valid and imem_req drop same cycle, busy=0, state IDLE.
